// File: rtl/qr_dec_pkg.sv
// Purpose: shared constants, state encoding and LFSR step for the QR syndrome path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package qr_dec_pkg;

  // Syndrome / LFSR width and trap threshold (hit when popcount <= T_DEF).
  localparam int R_DEF       = 36;
  localparam int T_DEF       = 5;
  localparam int N_SHIFT_DEF = 63;
  localparam logic [R_DEF-1:0] GPOLY_DEF = 36'h6_9B5C_2E47;

  // Popcount of an R_DEF-bit word needs ceil(log2(R_DEF+1)) bits.
  localparam int PCNT_W = $clog2(R_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x modulo g(x): shift up one place, fold the dropped x^R term
  // back in through the low-order generator coefficients.
  function automatic logic [R_DEF-1:0] lfsr_step(input logic [R_DEF-1:0] s,
                                                  input logic [R_DEF-1:0] gpoly);
    return {s[R_DEF-2:0], 1'b0} ^ (s[R_DEF-1] ? gpoly : '0);
  endfunction

endpackage

// File: rtl/synd_trap_seq_popcnt_le.sv
// Purpose: combinational test "popcount(d) <= TH".
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
module popcnt_le #(
  parameter int W  = 36,
  parameter int TH = 5
) (
  input  logic [W-1:0] d,
  output logic         le
);

  localparam int NG = (W + 2) / 3;
  localparam int SW = $clog2(W + 1);

  logic [NG*3-1:0] pad;
  logic [1:0]      grp [NG];
  logic [SW-1:0]   sum;

  // Zero-extend the input to a whole number of 3-bit groups.
  always_comb begin
    pad        = '0;
    pad[W-1:0] = d;
  end

  // Each 3-bit group reduces to a 2-bit count.
  always_comb begin
    for (int i = 0; i < NG; i++) begin
      grp[i] = {1'b0, pad[3*i]} + {1'b0, pad[3*i+1]} + {1'b0, pad[3*i+2]};
    end
  end

  // Reduce the group counts; synthesis is free to rebalance into a tree.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NG; i++) begin
      sum = sum + SW'(grp[i]);
    end
  end

  assign le = (sum <= SW'(TH));

endmodule

// File: rtl/synd_trap_seq.sv
// Purpose: error-trapping sequencer; steps a syndrome through cyclic shifts until its weight <= T.
// Latency: hit at shift k gives done k+2 cycles after start; a miss gives done N_SHIFT+1 cycles after start.
// Backpressure: start is ignored while busy; abort cancels a scan with no done pulse.
module synd_trap_seq
  import qr_dec_pkg::*;
#(
  parameter logic [R_DEF-1:0] GPOLY   = GPOLY_DEF,
  parameter int               N_SHIFT = N_SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [R_DEF-1:0]           synd_in,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [$clog2(N_SHIFT)-1:0] shift_cnt,
  output logic [R_DEF-1:0]           err_pat
);

  localparam int KW = $clog2(N_SHIFT);
  localparam logic [KW-1:0] K_LAST = KW'(N_SHIFT - 1);

  state_t           state;
  logic [R_DEF-1:0] s;
  logic [KW-1:0]    k;
  logic             hit;

  // The single shared weight checker, evaluated on the current shift every cycle.
  popcnt_le #(
    .W  (R_DEF),
    .TH (T_DEF)
  ) u_popcnt_le (
    .d  (s),
    .le (hit)
  );

  // Sequencer: load, scan shifts one per cycle, report, with abort/reset cancelling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      shift_cnt <= '0;
      err_pat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            s         <= synd_in;
            k         <= '0;
            found     <= 1'b0;
            shift_cnt <= '0;
            err_pat   <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end

        SCAN: begin
          if (abort) begin
            // Abort beats a same-cycle hit: drop everything, no done.
            found     <= 1'b0;
            shift_cnt <= '0;
            err_pat   <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (hit) begin
            found     <= 1'b1;
            shift_cnt <= k;
            err_pat   <= s;
            done      <= 1'b1;
            state     <= DONE;
          end else if (k == K_LAST) begin
            found     <= 1'b0;
            shift_cnt <= '0;
            err_pat   <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            s <= lfsr_step(s, GPOLY);
            k <= k + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (abort) begin
            found     <= 1'b0;
            shift_cnt <= '0;
            err_pat   <= '0;
          end
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synd_trap_seq.sv
// Purpose: scoreboard bench for synd_trap_seq across three generator polynomials.
// Latency: expected done cycles are queued with each stimulus and checked on done.
// Backpressure: exercises ignored start, abort and mid-scan reset.
module tb_synd_trap_seq;

  logic clk;
  logic rst;

  // Instance 0: default generator, 1: g = 0x3E, 2: g = 1 (pure rotation).
  logic        start_a   [3];
  logic [35:0] synd_a    [3];
  logic        abort_a   [3];
  logic        busy_a    [3];
  logic        done_a    [3];
  logic        found_a   [3];
  logic [5:0]  sc_a      [3];
  logic [35:0] ep_a      [3];

  synd_trap_seq u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .synd_in(synd_a[0]), .abort(abort_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .found(found_a[0]), .shift_cnt(sc_a[0]), .err_pat(ep_a[0])
  );

  synd_trap_seq #(.GPOLY(36'h0_0000_003E)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .synd_in(synd_a[1]), .abort(abort_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .found(found_a[1]), .shift_cnt(sc_a[1]), .err_pat(ep_a[1])
  );

  synd_trap_seq #(.GPOLY(36'h0_0000_0001)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .synd_in(synd_a[2]), .abort(abort_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .found(found_a[2]), .shift_cnt(sc_a[2]), .err_pat(ep_a[2])
  );

  typedef struct {
    int          inst;
    int          cyc;
    logic        found;
    logic [5:0]  sc;
    logic [35:0] ep;
  } res_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic        busy;
    logic        done;
    logic        found;
    logic [5:0]  sc;
    logic [35:0] ep;
  } probe_t;

  res_t   rq[$];
  probe_t pq[$];
  res_t   mon_r;
  probe_t mon_p;

  int cyc;
  int checks;
  int errors;
  int acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected results on done, expected snapshots at their cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_a[i] === 1'b1) begin
        checks = checks + 1;
        if (rq.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_done inst=%0d cyc=%0d (no done required)", i, cyc);
        end else begin
          mon_r = rq.pop_front();
          if (mon_r.inst != i || mon_r.cyc != cyc || found_a[i] !== mon_r.found ||
              sc_a[i] !== mon_r.sc || ep_a[i] !== mon_r.ep) begin
            errors = errors + 1;
            $display("FAIL result got inst=%0d cyc=%0d found=%b k=%0d pat=%h want inst=%0d cyc=%0d found=%b k=%0d pat=%h",
                     i, cyc, found_a[i], sc_a[i], ep_a[i],
                     mon_r.inst, mon_r.cyc, mon_r.found, mon_r.sc, mon_r.ep);
          end
        end
      end
    end
    if (rq.size() != 0 && rq[0].cyc < cyc) begin
      mon_r = rq.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missing_done inst=%0d got none by cyc=%0d want done at cyc=%0d",
               mon_r.inst, cyc, mon_r.cyc);
    end
    while (pq.size() != 0 && pq[0].cyc <= cyc) begin
      mon_p = pq.pop_front();
      checks = checks + 1;
      if (busy_a[mon_p.inst] !== mon_p.busy || done_a[mon_p.inst] !== mon_p.done ||
          found_a[mon_p.inst] !== mon_p.found || sc_a[mon_p.inst] !== mon_p.sc ||
          ep_a[mon_p.inst] !== mon_p.ep) begin
        errors = errors + 1;
        $display("FAIL snapshot inst=%0d cyc=%0d got busy=%b done=%b found=%b k=%0d pat=%h want busy=%b done=%b found=%b k=%0d pat=%h",
                 mon_p.inst, cyc, busy_a[mon_p.inst], done_a[mon_p.inst], found_a[mon_p.inst],
                 sc_a[mon_p.inst], ep_a[mon_p.inst],
                 mon_p.busy, mon_p.done, mon_p.found, mon_p.sc, mon_p.ep);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int inst, input int at, input logic f,
                            input logic [5:0] k, input logic [35:0] p);
    res_t r;
    r.inst = inst; r.cyc = at; r.found = f; r.sc = k; r.ep = p;
    rq.push_back(r);
  endtask

  task automatic expect_snap(input int inst, input int at, input logic b, input logic d,
                             input logic f, input logic [5:0] k, input logic [35:0] p);
    probe_t q;
    q.inst = inst; q.cyc = at; q.busy = b; q.done = d; q.found = f; q.sc = k; q.ep = p;
    pq.push_back(q);
  endtask

  // Drive start for one cycle; acc records the accepting cycle (cycle 0).
  task automatic do_start(input int inst, input logic [35:0] v);
    start_a[inst] = 1'b1;
    synd_a[inst]  = v;
    acc = cyc;
    tick();
    start_a[inst] = 1'b0;
  endtask

  task automatic wait_until(input int target);
    for (int n = 0; n < 200 && cyc < target; n++) tick();
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (rq.size() != 0 || pq.size() != 0); n++) tick();
    tick();
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    acc    = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      synd_a[i]  = '0;
      abort_a[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) expect_snap(i, cyc, 1'b0, 1'b0, 1'b0, 6'd0, 36'h0);
    tick();
    rst = 1'b0;
    tick();

    // Weight exactly T at shift 0: immediate hit.
    do_start(0, 36'h0_0000_001F);
    expect_res(0, acc + 2, 1'b1, 6'd0, 36'h0_0000_001F);
    drain();

    // Zero syndrome: trivially trapped at shift 0.
    do_start(0, 36'h0);
    expect_res(0, acc + 2, 1'b1, 6'd0, 36'h0);
    drain();

    // Weight 6 misses, one shift with g=0x3E cancels to zero.
    do_start(1, 36'h8_0000_001F);
    expect_snap(1, acc + 1, 1'b1, 1'b0, 1'b0, 6'd0, 36'h0);
    expect_res(1, acc + 3, 1'b1, 6'd1, 36'h0);
    drain();

    // Pure rotation keeps weight 6: exhausts all shifts.
    do_start(2, 36'h0_0000_003F);
    expect_res(2, acc + 64, 1'b0, 6'd0, 36'h0);
    drain();

    // A start during the scan with an immediately-trapping syndrome is ignored.
    do_start(2, 36'h0_0000_003F);
    expect_res(2, acc + 64, 1'b0, 6'd0, 36'h0);
    wait_until(acc + 5);
    start_a[2] = 1'b1;
    synd_a[2]  = 36'h0_0000_0001;
    tick();
    start_a[2] = 1'b0;
    drain();

    // Abort in cycle 10 of a miss scan, then a fresh scan from cycle 11.
    do_start(2, 36'h0_0000_003F);
    wait_until(acc + 10);
    abort_a[2] = 1'b1;
    expect_snap(2, acc + 11, 1'b0, 1'b0, 1'b0, 6'd0, 36'h0);
    tick();
    abort_a[2] = 1'b0;
    do_start(2, 36'h0_0000_001F);
    expect_res(2, acc + 2, 1'b1, 6'd0, 36'h0_0000_001F);
    drain();

    // Reset in cycle 4 of a miss scan: everything cleared, no done ever follows.
    do_start(2, 36'h0_0000_003F);
    wait_until(acc + 4);
    rst = 1'b1;
    expect_snap(2, acc + 5, 1'b0, 1'b0, 1'b0, 6'd0, 36'h0);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 70; n++) tick();
    drain();

    // Back-to-back: second start in the cycle right after done.
    do_start(0, 36'h0_0000_001F);
    expect_res(0, acc + 2, 1'b1, 6'd0, 36'h0_0000_001F);
    wait_until(acc + 3);
    do_start(0, 36'h0_0000_0007);
    expect_snap(0, acc + 1, 1'b1, 1'b0, 1'b0, 6'd0, 36'h0);
    expect_res(0, acc + 2, 1'b1, 6'd0, 36'h0_0000_0007);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/synd_trap_seq.md
# synd_trap_seq

Error-trapping sequencer for the 36-bit syndrome path of the QR decoder. It loads one syndrome, then steps it through successive cyclic-shift syndromes with an LFSR (multiply by x mod g(x)). Each step is checked by a popcount-threshold test, weight ≤ T. It reports the first shift at which the error pattern is trapped, or a failure once the shift limit is exhausted. It sits between the syndrome calculator and the error-correction stage and time-multiplexes a single weight checker across all shifts.

## Interface
- `R`, 36: syndrome / LFSR width.
- `T`, 5: trap threshold; a hit means popcount ≤ T.
- `N_SHIFT`, 63: number of shift positions checked, k = 0..N_SHIFT-1.
- `GPOLY`, 36'h6_9B5C_2E47: g(x) coefficients below x^R.
- `clk` input 1: the single clock; rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: load request; accepted only when `busy`=0.
- `synd_in` input R: syndrome, sampled with an accepted `start`.
- `abort` input 1: cancel the scan in progress; no `done` follows.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle completion pulse.
- `found` output 1: trap succeeded; valid from `done`, held until the next accepted `start`.
- `shift_cnt` output 6 (clog2 N_SHIFT): shift index k of the hit; 0 on fail.
- `err_pat` output R: trapped syndrome at the hit; 0 on fail.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, `start`=1: `s` ← `synd_in`, `k` ← 0, clear `found`/`shift_cnt`/`err_pat`, go to SCAN.
- SCAN, each cycle: `hit` = popcount(`s`) ≤ T, combinational.
  - `hit`: `found` ← 1, `shift_cnt` ← `k`, `err_pat` ← `s`, go to DONE.
  - No hit and `k` = N_SHIFT-1: `found` ← 0, `shift_cnt` ← 0, `err_pat` ← 0, go to DONE.
  - Otherwise: `s` ← {`s`[R-2:0],1'b0} ^ (`s`[R-1] ? GPOLY : 0), `k` ← `k`+1.
- DONE: `done`=1 for this one cycle, then go to IDLE.
- `start` while `busy`: ignored, no side effects.
- `abort` in SCAN or DONE: go to IDLE next edge, `done` stays 0, result registers cleared. `abort` in IDLE: no effect.
- `abort` and `hit` in the same cycle: `abort` wins.
- `start` and `abort` in the same IDLE cycle: `start` is accepted.
- Popcount width: ceil(log2(R+1)) = 6 bits; the comparison is unsigned.

## Timing
- Cycle 0: `start` accepted. Cycle 1+k: shift k is evaluated.
- Hit at shift k: `done` is high in cycle 2+k. Total latency k+2.
- Miss: `done` is high in cycle N_SHIFT+1.
- `busy` rises in cycle 1 and falls in the cycle after `done`, so back-to-back `start` is legal in that cycle.
- Reset values: `busy`=0, `done`=0, `found`=0, `shift_cnt`=0, `err_pat`=0; state IDLE, `s`=0, `k`=0.
- Reset mid-scan: all of the above hold at the next edge; no `done`.
- All outputs are registered. The popcount + compare + next-state path is the single combinational path per cycle.

## Structure
- Shared package `qr_dec_pkg`:
  - R, T, default GPOLY, the N_SHIFT default.
  - State enum {IDLE, SCAN, DONE}.
  - Popcount width constant.
- One sub-module, `popcnt_le`, parameterised by width and threshold.
  - Function: 3-bit group adds, then a group-sum tree, then ≤ T compare.
  - Purely combinational, single output `le`.
- The LFSR step is an inline function in the package: `lfsr_step(s, GPOLY)`.

## Test plan
- **Immediate hit:** `synd_in`=36'h0_0000_001F (weight 5) → `done` in cycle 2, `found`=1, `shift_cnt`=0, `err_pat`=36'h1F.
- **Hit after one shift:** GPOLY=36'h0_0000_003E, `synd_in`=36'h8_0000_001F (weight 6) → `done` in cycle 3, `found`=1, `shift_cnt`=1, `err_pat`=0.
- **Exhaustion:** GPOLY=36'h0_0000_0001 (pure rotation, weight invariant), `synd_in`=36'h0_0000_003F → `done` in cycle 64 (N_SHIFT=63), `found`=0, `shift_cnt`=0, `err_pat`=0.
- **Ignored start:** second `start` with a different `synd_in` in cycle 5 of a scan → ignored; results match the first syndrome only.
- **Abort:** `abort` in cycle 10 of a miss scan → `busy`=0 at cycle 11, no `done`. A fresh `start` in cycle 11 completes normally.
- **Reset mid-scan:** `rst` in cycle 4 → all outputs 0 next cycle, state IDLE. Also check `start` in the cycle right after `done` → a new scan begins.
